// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared lock-FSM states, default sizes and the eight-field timing record
package vga_rx_pkg;
  localparam int CW_DEF = 12;
  localparam int TIMEOUT_DEF = 4096;
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
  typedef struct packed {
    logic [CW_DEF-1:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
  } timing_t;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: two-flop register of W strobes (d) giving the older level s2 and rise/fall pulses from s2 vs s1
module vga_sync_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] s2,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;
endmodule

// File: rtl/vga_timing_analyzer.sv
// vga_timing_analyzer: from vga_hs/vs/de/rgb recovers meas_* geometry, locked/sync_err/frame_start, act_x/act_y and the probe pixel
module vga_timing_analyzer
  import vga_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_de,
  input  logic [7:0]    vga_r,
  input  logic [7:0]    vga_g,
  input  logic [7:0]    vga_b,
  input  logic [9:0]    probe_x,
  input  logic [9:0]    probe_y,
  output logic [CW-1:0] meas_h_total,
  output logic [CW-1:0] meas_h_sync,
  output logic [CW-1:0] meas_h_start,
  output logic [CW-1:0] meas_h_end,
  output logic [CW-1:0] meas_v_total,
  output logic [CW-1:0] meas_v_sync,
  output logic [CW-1:0] meas_v_start,
  output logic [CW-1:0] meas_v_end,
  output logic          locked,
  output logic          frame_start,
  output logic [CW-1:0] act_x,
  output logic [CW-1:0] act_y,
  output logic          probe_valid,
  output logic [7:0]    probe_r,
  output logic [7:0]    probe_g,
  output logic [7:0]    probe_b,
  output logic          sync_err
);
  localparam logic [CW-1:0] CMAX = '1;
  logic [2:0] lvl, rise, fall;
  logic [23:0] rgb_s1, rgb_s2;
  logic hs_f, hs_r, vs_f, vs_r, de_f, de_r, de2, unused_lvl;
  logic [CW-1:0] hc, vc, hc_inc, hc_cur, vc_cur;
  logic line_de, frame_de, line_mis, mis_now, bad, timeout, probe_hit;
  timing_t shadow, shadow_nx, meas;
  state_t state;
  vga_sync_edge #(.W(3)) u_edge (
    .clk  (clk),
    .reset(reset),
    .d    ({vga_de, vga_vs, vga_hs}),
    .s2   (lvl),
    .rise (rise),
    .fall (fall)
  );
  assign {de_r, vs_r, hs_r} = rise;
  assign {de_f, vs_f, hs_f} = fall;
  assign de2 = lvl[2];
  assign unused_lvl = ^lvl[1:0];
  assign hc_inc = hc == CMAX ? hc : hc + 1'b1;
  assign hc_cur = hs_f ? '0 : hc_inc;
  assign vc_cur = vs_f ? '0 : (hs_f && vc != CMAX) ? vc + 1'b1 : vc;
  assign mis_now = hs_f && hc != shadow.h_total;
  assign bad = line_mis || mis_now || shadow_nx != meas;
  assign timeout = !hs_f && hc_inc == CW'(TIMEOUT_CYC - 1) && hc != CW'(TIMEOUT_CYC - 1);
  assign probe_hit = de2 && act_x == CW'(probe_x) && act_y == CW'(probe_y);
  assign locked = state == LOCKED;
  assign {meas_h_total, meas_h_sync, meas_h_start, meas_h_end,
          meas_v_total, meas_v_sync, meas_v_start, meas_v_end} = meas;
  // h_end/v_end use the pre-fall counters so a DE that runs to the end of a line or frame still lands on its own line
  always_comb begin
    shadow_nx = shadow;
    if (hs_f) shadow_nx.h_total = hc;
    if (hs_r) shadow_nx.h_sync = hc_cur;
    if (de_r && (hs_f || !line_de)) shadow_nx.h_start = hc_cur;
    if (de_f) shadow_nx.h_end = hc_inc;
    if (vs_r) shadow_nx.v_sync = vc_cur;
    if (de_r && (vs_f || !frame_de)) shadow_nx.v_start = vc_cur;
    if (de_f) shadow_nx.v_end = vc + 1'b1;
    if (vs_f) shadow_nx.v_total = vc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rgb_s1 <= '0;
      rgb_s2 <= '0;
      hc <= '0;
      vc <= '0;
      shadow <= '0;
      meas <= '0;
      line_de <= 1'b0;
      frame_de <= 1'b0;
      line_mis <= 1'b0;
      act_x <= '0;
      act_y <= '0;
      probe_valid <= 1'b0;
      {probe_r, probe_g, probe_b} <= '0;
      frame_start <= 1'b0;
      sync_err <= 1'b0;
      state <= SEARCH;
    end else begin
      rgb_s1 <= {vga_r, vga_g, vga_b};
      rgb_s2 <= rgb_s1;
      hc <= hc_cur;
      vc <= vc_cur;
      shadow <= shadow_nx;
      line_de <= hs_f ? de_r : line_de | de_r;
      frame_de <= vs_f ? de_r : frame_de | de_r;
      line_mis <= !vs_f && (line_mis || mis_now);
      act_x <= de_r ? '0 : de2 ? act_x + 1'b1 : act_x;
      act_y <= vs_f ? '0 : de_f ? act_y + 1'b1 : act_y;
      probe_valid <= probe_hit;
      if (probe_hit) {probe_r, probe_g, probe_b} <= rgb_s2;
      frame_start <= vs_f;
      if (vs_f && state != SEARCH) meas <= shadow_nx;
      sync_err <= timeout ? state == LOCKED : vs_f && state == LOCKED && bad;
      state <= timeout ? SEARCH : !vs_f ? state : state == SEARCH ? MEASURE :
               state == MEASURE ? VERIFY : bad ? MEASURE : LOCKED;
    end
endmodule
